// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct codes,
// ALU operation codes, sequencer state codes and the per-state control word.
package mips_pkg;

  // Opcodes, Instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes, Instr[5:0]
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_MUL = 6'b011100;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;

  // ALUControl codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  // Sequencer states; codes are visible on the State debug port
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEXEC = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  // ALU B operand and PC source selects
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // Everything a state asserts, before the PC-enable and reset gating
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_e    alu_op;
    logic [1:0] pc_src;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the sequencer's coarse ALU request plus the R-type funct field onto
// the 3-bit ALUControl code.
module alu_decoder
  import mips_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    // NOTE: a default assignment before the case keeps every path driven, so no latch is inferred.
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_control = ALU_ADD;
          FUNCT_SUB: alu_control = ALU_SUB;
          FUNCT_SLT: alu_control = ALU_SLT;
          FUNCT_MUL: alu_control = ALU_MUL;
          FUNCT_AND: alu_control = ALU_AND;
          FUNCT_OR:  alu_control = ALU_OR;
          default:   alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multicycle MIPS datapath: state register, next-state
// logic and per-state control decode; ALUControl comes from alu_decoder.
module multicycle_control_fsm
  import mips_pkg::*;
#(
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [INSTR_WIDTH-1:0] Instr,
  input  logic                   Zero,
  input  logic                   MemReady,
  output logic                   PCEn,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   RegDst,
  output logic                   MemtoReg,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [2:0]             ALUControl,
  output logic [1:0]             PCSrc,
  output logic                   Illegal,
  output logic [3:0]             State
);

  logic [3:0] state;
  logic [3:0] next_state;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       op_supported;
  ctrl_t      ctrl;
  logic       instr_unused;

  assign opcode = Instr[31:26];
  assign funct  = Instr[5:0];
  // Only the opcode and funct fields steer the sequencer
  assign instr_unused = ^Instr;

  always_comb begin
    op_supported = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J: op_supported = 1'b1;
      default:                                       op_supported = 1'b0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_FETCH;
    else      state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_ADDI:      next_state = S_ADDIEXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    next_state = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWR:    next_state = MemReady ? S_FETCH : S_MEMWR;
      S_EXECUTE:  next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_ADDIEXEC: next_state = S_ADDIWB;
      S_ADDIWB:   next_state = S_FETCH;
      S_JUMP:     next_state = S_FETCH;
      default:    next_state = S_FETCH;
    endcase
  end

  // Unused codes 12-15 fall through to the all-zero control word
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = MemReady;
        ctrl.pc_write  = MemReady;
        ctrl.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.illegal   = !op_supported;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl.alu_op),
    .funct       (funct),
    .alu_control (ALUControl)
  );

  // While reset is held the PC and IR must not load even if memory reports ready
  assign PCEn     = RST & (ctrl.pc_write | (ctrl.branch & Zero));
  assign IRWrite  = RST & ctrl.ir_write;
  assign IorD     = ctrl.iord;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign RegDst   = ctrl.reg_dst;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign PCSrc    = ctrl.pc_src;
  assign Illegal  = ctrl.illegal;
  assign State    = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: stimulus walks each instruction
// through its step list and queues expected outputs; a monitor compares them.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctl;
    logic [1:0] pc_src;
    logic       illegal;
    logic [3:0] state;
  } obs_t;

  localparam logic [31:0] I_LW   = 32'h8C08_0004;
  localparam logic [31:0] I_SW   = 32'hAC08_0004;
  localparam logic [31:0] I_SUB  = 32'h0109_5022;
  localparam logic [31:0] I_MUL  = 32'h0109_501C;
  localparam logic [31:0] I_AND  = 32'h0109_5024;
  localparam logic [31:0] I_OR   = 32'h0109_5025;
  localparam logic [31:0] I_SLT  = 32'h0109_502A;
  localparam logic [31:0] I_NOR  = 32'h0109_5027;
  localparam logic [31:0] I_ADDI = 32'h2108_0005;
  localparam logic [31:0] I_BEQ  = 32'h1109_0003;
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_ILL  = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pcen, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic        reg_write, alu_src_a, illegal;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_ctl;
  logic [3:0]  state;

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  multicycle_control_fsm #(.INSTR_WIDTH(32)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .Instr      (instr),
    .Zero       (zero),
    .MemReady   (mem_ready),
    .PCEn       (pcen),
    .IorD       (iord),
    .MemRead    (mem_read),
    .MemWrite   (mem_write),
    .IRWrite    (ir_write),
    .RegDst     (reg_dst),
    .MemtoReg   (mem_to_reg),
    .RegWrite   (reg_write),
    .ALUSrcA    (alu_src_a),
    .ALUSrcB    (alu_src_b),
    .ALUControl (alu_ctl),
    .PCSrc      (pc_src),
    .Illegal    (illegal),
    .State      (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ALU code an R-type funct should select
  function automatic logic [2:0] ref_alu(input logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b100;
      6'h2A:   return 3'b110;
      6'h1C:   return 3'b101;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  // Step list of each instruction class, by documented state number; -1 ends it
  function automatic int step_at(input logic [5:0] op, input int i);
    int seq [6];
    case (op)
      6'b100011: seq = '{0, 1, 2, 3, 4, -1};
      6'b101011: seq = '{0, 1, 2, 5, -1, -1};
      6'b000000: seq = '{0, 1, 6, 7, -1, -1};
      6'b001000: seq = '{0, 1, 9, 10, -1, -1};
      6'b000100: seq = '{0, 1, 8, -1, -1, -1};
      6'b000010: seq = '{0, 1, 11, -1, -1, -1};
      default:   seq = '{0, 1, -1, -1, -1, -1};
    endcase
    return (i < 6) ? seq[i] : -1;
  endfunction

  function automatic bit op_known(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
  endfunction

  // Expected outputs for one cycle in documented state st
  function automatic obs_t expect_out(input int st, input logic mr, input logic z,
                                      input logic [31:0] ins);
    obs_t e;
    e = '0;
    e.state   = 4'(st);
    e.alu_ctl = 3'b010;
    case (st)
      0:  begin e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pcen = mr; end
      1:  begin e.alu_src_b = 2'b11; e.illegal = !op_known(ins[31:26]); end
      2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      3:  begin e.mem_read = 1'b1; e.iord = 1'b1; end
      4:  begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
      5:  begin e.mem_write = 1'b1; e.iord = 1'b1; end
      6:  begin e.alu_src_a = 1'b1; e.alu_ctl = ref_alu(ins[5:0]); end
      7:  begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
      8:  begin e.alu_src_a = 1'b1; e.alu_ctl = 3'b100; e.pc_src = 2'b01; e.pcen = z; end
      9:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      10: e.reg_write = 1'b1;
      11: begin e.pc_src = 2'b10; e.pcen = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Runs one instruction from FETCH; entered and left at posedge+1.
  // rnd=1 randomizes MemReady/Zero; otherwise MemReady is 1 except for
  // wr_stalls low cycles in MEMWR, and Zero is z_fix.
  task automatic run_instr(input logic [31:0] ins, input bit rnd, input int wr_stalls,
                           input logic z_fix);
    int   i;
    int   st;
    int   stalls;
    logic mr;
    logic z;
    instr = ins;
    i = 0;
    st = step_at(ins[31:26], 0);
    while (st >= 0) begin
      stalls = 0;
      forever begin
        if (rnd) begin
          mr = ($urandom_range(0, 3) != 0) || (stalls >= 4);
          z  = 1'($urandom_range(0, 1));
        end else begin
          mr = !(st == 5 && stalls < wr_stalls);
          z  = z_fix;
        end
        mem_ready = mr;
        zero      = z;
        exp_q.push_back(expect_out(st, mr, z, ins));
        @(posedge clk);
        #1;
        if (!(st inside {0, 3, 5}) || mr) break;
        stalls++;
      end
      i++;
      st = step_at(ins[31:26], i);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  fn [6];
    fn = '{6'h20, 6'h22, 6'h2A, 6'h1C, 6'h24, 6'h25};
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[31:26] = 6'b100011;
      1: r[31:26] = 6'b101011;
      2: begin r[31:26] = 6'b000000; r[5:0] = fn[$urandom_range(0, 5)]; end
      3: r[31:26] = 6'b001000;
      4: r[31:26] = 6'b000100;
      5: r[31:26] = 6'b000010;
      6: r[31:26] = 6'b000000;
      default: ;
    endcase
    return r;
  endfunction

  // Monitor: every cycle with a queued expectation is compared at the falling edge
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{pcen, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
              reg_write, alu_src_a, alu_src_b, alu_ctl, pc_src, illegal, state};
        check("state", 32'(a.state), 32'(e.state));
        check($sformatf("outputs in state %0d", e.state), 32'(a), 32'(e));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b0;
    instr     = I_LW;
    #3;
    check("reset state", 32'(state), 32'd0);
    check("reset pcen", 32'(pcen), 32'd0);
    check("reset irwrite", 32'(ir_write), 32'd0);
    check("reset memread", 32'(mem_read), 32'd1);
    check("reset alusrcb", 32'(alu_src_b), 32'd1);
    check("reset regwrite", 32'(reg_write), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_instr(I_LW,   1'b0, 0, 1'b0);
    run_instr(I_SW,   1'b0, 2, 1'b0);
    run_instr(I_SUB,  1'b0, 0, 1'b0);
    run_instr(I_MUL,  1'b0, 0, 1'b0);
    run_instr(I_AND,  1'b0, 0, 1'b0);
    run_instr(I_OR,   1'b0, 0, 1'b0);
    run_instr(I_SLT,  1'b0, 0, 1'b0);
    run_instr(I_NOR,  1'b0, 0, 1'b0);
    run_instr(I_ADDI, 1'b0, 0, 1'b0);
    run_instr(I_BEQ,  1'b0, 0, 1'b1);
    run_instr(I_BEQ,  1'b0, 0, 1'b0);
    run_instr(I_J,    1'b0, 0, 1'b0);
    run_instr(I_ILL,  1'b0, 0, 1'b0);

    // Abort a load in its writeback cycle with an asynchronous reset
    instr     = I_LW;
    mem_ready = 1'b1;
    zero      = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(expect_out(k, 1'b1, 1'b0, I_LW));
      @(posedge clk);
      #1;
    end
    #1;
    check("pre-abort state", 32'(state), 32'd4);
    check("pre-abort regwrite", 32'(reg_write), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort state", 32'(state), 32'd0);
    check("abort regwrite", 32'(reg_write), 32'd0);
    check("abort memtoreg", 32'(mem_to_reg), 32'd0);
    check("abort pcen", 32'(pcen), 32'd0);
    check("abort irwrite", 32'(ir_write), 32'd0);
    @(posedge clk);
    #1;
    check("held reset state", 32'(state), 32'd0);
    rst_n = 1'b1;
    run_instr(I_LW, 1'b0, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      run_instr(rand_instr(), 1'b1, 0, 1'b0);
    end

    @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multicycle MIPS control sequencer that drives a shared-memory, shared-ALU datapath from one instruction register. Steps each instruction through FETCH/DECODE/execute/writeback states and emits per-state datapath selects and write strobes. Stalls on a memory-ready handshake. Supports lw, sw, R-type (add, sub, slt, mul, and, or), addi, beq and j.

## Interface
- `INSTR_WIDTH`, default 32: instruction register width.
- `CLK` input, 1: rising-edge clock.
- `RST` input, 1: asynchronous, active-low reset.
- `Instr` input, INSTR_WIDTH: instruction register contents.
  - Opcode = [31:26], Funct = [5:0].
- `Zero` input, 1: ALU zero flag.
- `MemReady` input, 1: memory completes the current access this cycle.
- `PCEn` output, 1: PC register enable, `PCWrite | (Branch & Zero)`.
- `IorD` output, 1: memory address select, 0 = PC, 1 = ALUOut.
- `MemRead` output, 1: memory read request.
- `MemWrite` output, 1: memory write request.
- `IRWrite` output, 1: instruction register load.
- `RegDst` output, 1: register write address select, 0 = rt, 1 = rd.
- `MemtoReg` output, 1: register write data select, 0 = ALUOut, 1 = Data.
- `RegWrite` output, 1: register file write.
- `ALUSrcA` output, 1: ALU A select, 0 = PC, 1 = A.
- `ALUSrcB` output, 2: ALU B select, 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUControl` output, 3: ALU operation code.
- `PCSrc` output, 2: PC source select, 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `Illegal` output, 1: one-cycle pulse on an unsupported opcode.
- `State` output, 4: current state, for debug and verification.

## Operation
Moore FSM; all outputs decode combinationally from `State`, plus `MemReady`, `Zero` and `Funct` where noted. Outputs not listed for a state are 0, and `ALUControl` defaults to add (010).

States and outputs:
- **FETCH (0)**
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00.
  - IRWrite and PCWrite are driven equal to `MemReady`.
  - Stays in FETCH while `MemReady`=0; goes to DECODE on `MemReady`=1.
- **DECODE (1)**
  - Outputs: ALUSrcA=0, ALUSrcB=11, add (precomputes the branch target).
  - Next state by opcode: 100011/101011 → MEMADR, 000000 → EXECUTE, 001000 → ADDIEXEC, 000100 → BRANCH, 000010 → JUMP.
  - Any other opcode: Illegal=1, return to FETCH.
- **MEMADR (2)**
  - Outputs: ALUSrcA=1, ALUSrcB=10, add.
  - Next: lw → MEMRD, sw → MEMWR.
- **MEMRD (3)**
  - Outputs: MemRead=1, IorD=1.
  - Holds until `MemReady`, then → MEMWB.
- **MEMWB (4)**
  - Outputs: RegDst=0, MemtoReg=1, RegWrite=1.
  - Next: FETCH.
- **MEMWR (5)**
  - Outputs: MemWrite=1, IorD=1.
  - MemWrite is held until `MemReady`, then → FETCH.
- **EXECUTE (6)**
  - Outputs: ALUSrcA=1, ALUSrcB=00, `ALUControl` from Funct:
    - add 100000 → 010
    - sub 100010 → 100
    - slt 101010 → 110
    - mul 011100 → 101
    - and 100100 → 000
    - or 100101 → 001
    - any other Funct → 010
  - Next: ALUWB.
- **ALUWB (7)**
  - Outputs: RegDst=1, MemtoReg=0, RegWrite=1.
  - Next: FETCH.
- **BRANCH (8)**
  - Outputs: ALUSrcA=1, ALUSrcB=00, sub (100), PCSrc=01, Branch=1.
  - Next: FETCH.
- **ADDIEXEC (9)**
  - Outputs: ALUSrcA=1, ALUSrcB=10, add.
  - Next: ADDIWB.
- **ADDIWB (10)**
  - Outputs: RegDst=0, RegWrite=1.
  - Next: FETCH.
- **JUMP (11)**
  - Outputs: PCSrc=10, PCWrite=1.
  - Next: FETCH.
- **Codes 12–15**: all outputs 0, next state FETCH.

## Timing
- Reset (`RST`=0):
  - `State`=FETCH immediately (asynchronous).
  - Outputs then follow FETCH decode: MemRead=1, ALUSrcB=01, PCEn=IRWrite=`MemReady`.
  - During reset, PCEn and IRWrite are forced to 0 regardless of `MemReady`.
  - All other outputs are 0.
- Reset asserted mid-instruction aborts it. No partial write may occur after the asserting edge.
- Cycles per instruction with `MemReady` held at 1:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.
- Each low cycle of `MemReady` in FETCH, MEMRD or MEMWR adds exactly one cycle.
  - Requests stay asserted and addresses stay stable throughout the stall.
- `PCEn` in BRANCH is combinational on `Zero` in the same cycle.
- `Illegal` is high only during the DECODE cycle of an unsupported opcode.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants (including LW, SW, RTYPE, ADDI, BEQ, J);
  - funct constants (ADD, SUB, SLT, MUL, AND, OR);
  - `ALUControl` codes (010/100/110/101/000/001);
  - 4-bit state encodings.
- One sub-module, `alu_decoder`: ALUOp[1:0] and Funct → `ALUControl`.
  - 00 → add, 01 → sub, 10 → Funct table above.
- The FSM keeps only the state register, next-state logic and output decode.

## Test plan
- Reset with `MemReady`=1, `Instr`=lw (0x8C080004):
  - `State` sequence 0,1,2,3,4,0.
  - RegWrite=1 and MemtoReg=1 only in state 4.
- sw (0xAC080004), `MemReady` low for 2 cycles in MEMWR:
  - MemWrite and IorD high for 3 cycles, then FETCH.
  - RegWrite never asserted.
- R-type sub (0x01095022): EXECUTE with ALUControl=100, then ALUWB with RegDst=1.
  - Repeat for mul (Funct 011100): ALUControl=101.
- beq (0x11090003):
  - `Zero`=1 → PCEn=1 with PCSrc=01 in state 8.
  - `Zero`=0 → PCEn=0.
- j (0x08000010) → PCEn=1, PCSrc=10 in state 11.
  - Opcode 111111 → Illegal pulse in DECODE, back to FETCH with no write strobes.
- `RST` asserted in MEMWB → `State`=0 asynchronously, RegWrite drops the same cycle.
  - After release, fetch resumes.
